ntt_coef_collector: RTL and testbench

Destination-side receiver for the 32-bit clk1→clk2 handshake path. Runs in the NTT clock domain: accepts one handshake word per `in_valid` pulse, unpacks eight 4-bit coefficients per word into a 128-entry coefficient buffer, and holds `busy` so no further words arrive while the NTT core consumes the polynomial. It is the receiving end of the clk1 input module's transfer stream and feeds the NTT core through a registered read port.

---
 rtl/ntt_pkg.sv | 26 ++
 rtl/ntt_coef_buf.sv | 50 +++++
 rtl/ntt_coef_collector.sv | 142 ++++++++++++++
 tb/tb_ntt_coef_collector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and types for the NTT coefficient collector.
//   WORDS  - handshake words per polynomial
//   LANES  - coefficients packed per word
//   CW     - coefficient width in bits
//   NCOEF  - coefficients per polynomial (WORDS*LANES)
//   ADDR_W - coefficient index width
//   state_t - collector FSM states
package ntt_pkg;

    localparam int WORDS  = 16;
    localparam int LANES  = 8;
    localparam int CW     = 4;
    localparam int NCOEF  = WORDS * LANES;
    localparam int ADDR_W = $clog2(NCOEF);
    localparam int WIDX_W = $clog2(WORDS);
    localparam int LANE_W = $clog2(LANES);
    localparam int DW     = LANES * CW;
    localparam int RD_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/ntt_coef_buf.sv
// ntt_coef_buf: NCOEF x CW coefficient register file.
// Ports:
//   clk, rst_n - clock, async active-low reset (read register only)
//   we         - write all LANES coefficients of one word
//   wr_word    - word index; lane k lands at {wr_word, k}
//   wr_data    - packed word, lane k = wr_data[k*CW +: CW]
//   rd_addr    - coefficient index
//   rd_data    - registered read, zero-extended to RD_W bits
module ntt_coef_buf
    import ntt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [WIDX_W-1:0] wr_word,
    input  logic [DW-1:0]     wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [RD_W-1:0]   rd_data
);

    logic [NCOEF-1:0][CW-1:0] mem_q, mem_d;
    logic [RD_W-1:0]          rd_data_q, rd_data_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int k = 0; k < LANES; k++) begin
                mem_d[{wr_word, LANE_W'(k)}] = wr_data[k*CW +: CW];
            end
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Reads see the array before any same-cycle write.
    always_comb begin
        rd_data_d = {{(RD_W-CW){1'b0}}, mem_q[rd_addr]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ntt_coef_collector.sv
// ntt_coef_collector: clk2-side receiver that gathers WORDS handshake words
// into one polynomial and holds it until the NTT core releases it.
// Optional feature macro: COLLECT_TIMEOUT_EN - discard a partial polynomial
// after 2^TO_W-1 cycles without a word while collecting.
// Ports:
//   clk, rst_n  - clk2 domain clock, async active-low reset
//   in_valid    - one-cycle word strobe from the handshake synchronizer
//   in_data     - eight packed 4-bit coefficients
//   busy        - buffer held (registered, drives handshake dbusy)
//   poly_ready  - one-cycle pulse on polynomial completion
//   core_done   - one-cycle release pulse from the NTT core
//   rd_addr     - coefficient index for the core read port
//   rd_data     - registered {12'b0, coef[rd_addr]}
//   word_cnt    - words accepted in the current polynomial
//   err_overrun - sticky, a word arrived while the buffer was held
//   timeout     - one-cycle pulse, partial polynomial discarded
module ntt_coef_collector
    import ntt_pkg::*;
#(
    parameter int TO_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    output logic              busy,
    output logic              poly_ready,
    input  logic              core_done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [RD_W-1:0]   rd_data,
    output logic [WIDX_W-1:0] word_cnt,
    output logic              err_overrun,
    output logic              timeout
);

    state_t            state_q, state_d;
    logic [WIDX_W-1:0] word_cnt_q, word_cnt_d;
    logic              busy_q, busy_d;
    logic              poly_ready_q, poly_ready_d;
    logic              err_overrun_q, err_overrun_d;
    logic              timeout_q, timeout_d;
    logic              buf_we;

`ifdef COLLECT_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}};
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        poly_ready_d  = 1'b0;
        err_overrun_d = err_overrun_q;
        timeout_d     = 1'b0;
        buf_we        = 1'b0;
`ifdef COLLECT_TIMEOUT_EN
        to_cnt_d      = '0;
`endif
        case (state_q)
            IDLE: begin
                // word_cnt is 0 here, so the write lands at base 0.
                if (in_valid) begin
                    buf_we     = 1'b1;
                    word_cnt_d = WIDX_W'(1);
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    buf_we = 1'b1;
                    if (word_cnt_q == WIDX_W'(WORDS-1)) begin
                        word_cnt_d   = '0;
                        state_d      = FULL;
                        poly_ready_d = 1'b1;
                    end else begin
                        word_cnt_d = word_cnt_q + WIDX_W'(1);
                    end
                end
`ifdef COLLECT_TIMEOUT_EN
                // Firing when the count would step onto TO_LAST means the
                // timeout lands exactly 2^TO_W-1 idle cycles after the last word.
                else if (to_cnt_q == TO_LAST - TO_W'(1)) begin
                    state_d    = IDLE;
                    word_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            FULL: begin
                // A word here is dropped even when core_done arrives with it.
                if (in_valid)  err_overrun_d = 1'b1;
                if (core_done) state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            busy_q        <= 1'b0;
            poly_ready_q  <= 1'b0;
            err_overrun_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            busy_q        <= busy_d;
            poly_ready_q  <= poly_ready_d;
            err_overrun_q <= err_overrun_d;
            timeout_q     <= timeout_d;
        end
    end

`ifdef COLLECT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`endif

    ntt_coef_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (buf_we),
        .wr_word (word_cnt_q),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign busy        = busy_q;
    assign poly_ready  = poly_ready_q;
    assign word_cnt    = word_cnt_q;
    assign err_overrun = err_overrun_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_ntt_coef_collector.sv
// Testbench for ntt_coef_collector: randomized and directed words checked
// against a polynomial-level reference model through a scoreboard.
module tb_ntt_coef_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        core_done = 1'b0;
    logic [6:0]  rd_addr = '0;
    logic        busy, poly_ready, err_overrun, timeout;
    logic [15:0] rd_data;
    logic [3:0]  word_cnt;

    always #5 clk = ~clk;

`ifdef COLLECT_TIMEOUT_EN
    localparam int TB_TO_W = 4;
`else
    localparam int TB_TO_W = 10;
`endif

    ntt_coef_collector #(.TO_W(TB_TO_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .busy        (busy),
        .poly_ready  (poly_ready),
        .core_done   (core_done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .word_cnt    (word_cnt),
        .err_overrun (err_overrun),
        .timeout     (timeout)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: coefficient array plus polynomial bookkeeping.
    logic [3:0]  m_mem [128];
    int          m_cnt  = 0;
    bit          m_full = 0;
    bit          m_ovr  = 0;
    int          polys_expected = 0;

    int          pq[$];       // expected poly_ready cycles
    logic [15:0] rdq[$];      // expected read data
    int          cyc = 0;
    bit          rd_issue = 0;
    bit          rd_tag = 0;
    int          poly_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_tag <= rd_issue;
    end

    // Monitor: consumes expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (poly_ready) begin
                poly_seen++;
                if (pq.size() == 0) check("poly_ready_unexpected", 1, 0);
                else begin
                    check("poly_ready_cycle", cyc, pq.pop_front());
                    check("poly_busy", {31'b0, busy}, 1);
                end
            end
            if (rd_tag) begin
                if (rdq.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_data", {16'b0, rd_data}, {16'b0, rdq.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_word(input logic [31:0] d);
        if (m_full) m_ovr = 1;
        else begin
            for (int k = 0; k < 8; k++) m_mem[m_cnt*8 + k] = d[4*k +: 4];
            if (m_cnt == 15) begin
                m_full = 1;
                m_cnt  = 0;
                pq.push_back(cyc);
                polys_expected++;
            end else m_cnt++;
        end
    endtask

    task automatic send(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        model_word(d);
        check("word_cnt", {28'b0, word_cnt}, m_cnt);
        check("busy", {31'b0, busy}, {31'b0, m_full});
        check("err_overrun", {31'b0, err_overrun}, {31'b0, m_ovr});
    endtask

    task automatic done(input bit with_word, input logic [31:0] d);
        core_done = 1'b1;
        in_valid  = with_word;
        in_data   = d;
        tick();
        core_done = 1'b0;
        in_valid  = 1'b0;
        if (m_full) begin
            if (with_word) m_ovr = 1;
            m_full = 0;
        end else if (with_word) model_word(d);
        check("busy_after_done", {31'b0, busy}, {31'b0, m_full});
        check("err_overrun_after_done", {31'b0, err_overrun}, {31'b0, m_ovr});
        check("word_cnt_after_done", {28'b0, word_cnt}, m_cnt);
    endtask

    task automatic rd(input int a);
        rd_addr  = a[6:0];
        rd_issue = 1'b1;
        rdq.push_back({12'b0, m_mem[a]});
        tick();
        rd_issue = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_issue = 1'b0;
        #2;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_poly_ready", {31'b0, poly_ready}, 0);
        check("rst_err_overrun", {31'b0, err_overrun}, 0);
        check("rst_timeout", {31'b0, timeout}, 0);
        check("rst_word_cnt", {28'b0, word_cnt}, 0);
        check("rst_rd_data", {16'b0, rd_data}, 0);
        m_cnt = 0; m_full = 0; m_ovr = 0;
        pq.delete();
        rdq.delete();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int tcount;
        for (int i = 0; i < 128; i++) m_mem[i] = '0;
        do_reset();
        tick();

        // Full load, back-to-back words.
        for (int i = 0; i < 16; i++) send(32'h76543210 + i);
        rd(0); rd(7); rd(8); rd(127);
        for (int i = 0; i < 8; i++) rd($urandom_range(127));

        // Release, then all-F polynomial.
        done(0, 0);
        for (int i = 0; i < 16; i++) send(32'hFFFFFFFF);
        for (int i = 0; i < 128; i++) rd(i);

        // Overrun while held, and coincident with core_done.
        send(32'h0);
        done(1, 32'h0);
        rd(0);

        // core_done outside FULL is ignored.
        done(0, 0);

        // Gapped input.
        for (int i = 0; i < 16; i++) begin
            send($urandom);
            tick(); tick(); tick(); tick(); tick();
        end
        for (int i = 0; i < 10; i++) rd($urandom_range(127));
        done(0, 0);

        // Randomized polynomials with random gaps and stray core_done.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) begin
                send($urandom);
                if (i < 15 && $urandom_range(3) == 0) done(0, 0);
                repeat ($urandom_range(3)) tick();
            end
            for (int i = 0; i < 20; i++) rd($urandom_range(127));
            done(0, 0);
        end

        // Reset mid-collection, then a fresh load.
        for (int i = 0; i < 9; i++) send($urandom);
        do_reset();
        tick();
        for (int i = 0; i < 16; i++) send($urandom);
        for (int i = 0; i < 16; i++) rd($urandom_range(127));
        rd(0); rd(127);
        done(0, 0);

        // Partial polynomial left idle.
        for (int i = 0; i < 3; i++) send(32'h12345678 + i);
        tcount = 0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (timeout) tcount++;
        end
`ifdef COLLECT_TIMEOUT_EN
        check("timeout_pulses", tcount, 1);
        m_cnt = 0;
`else
        check("timeout_pulses", tcount, 0);
`endif
        check("word_cnt_after_idle", {28'b0, word_cnt}, m_cnt);
        check("busy_after_idle", {31'b0, busy}, 0);
        do_reset();

        repeat (4) tick();
        check("pq_drained", pq.size(), 0);
        check("rdq_drained", rdq.size(), 0);
        check("poly_count", poly_seen, polys_expected);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
